// File: rtl/alu_issue.sv
// Decode/issue stage in front of the ALU: decodes instruction + register operands
// into ALU controls and presents them through a 2-entry (output + skid) registered buffer.
module alu_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] ra_data,
    input  logic [DATA_W-1:0] rb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [4:0]        alu_shift,
    output logic [4:0]        out_rd,
    output logic              illegal,
    output logic [CNT_W-1:0]  issue_count
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned SH_W   = 5;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned OPC_W  = 6;

    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_SLW = 3'd4;
    localparam logic [OP_W-1:0] ALU_SRW = 3'd5;
    localparam logic [OP_W-1:0] ALU_ID  = 3'd6;

    localparam logic [OPC_W-1:0] OPC_ADD  = 6'h00;
    localparam logic [OPC_W-1:0] OPC_SUB  = 6'h01;
    localparam logic [OPC_W-1:0] OPC_AND  = 6'h02;
    localparam logic [OPC_W-1:0] OPC_OR   = 6'h03;
    localparam logic [OPC_W-1:0] OPC_SLW  = 6'h04;
    localparam logic [OPC_W-1:0] OPC_SRW  = 6'h05;
    localparam logic [OPC_W-1:0] OPC_ADDI = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LI   = 6'h09;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [SH_W-1:0]   shift;
        logic [RD_W-1:0]   rd;
    } issue_t;

    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm16;
    logic [DATA_W-1:0] imm_sx;
    logic              unused_reg_fields;

    issue_t dec;
    logic   dec_legal;

    issue_t or_q, or_d, sr_q, sr_d;
    logic   or_valid, or_valid_d;
    logic   sr_full, sr_full_d;
    logic   in_ready_q;
    logic   illegal_q;
    logic [CNT_W-1:0] count_q;

    logic accept, push, fire_out;

    assign opcode = instr[31:26];
    assign imm16  = instr[15:0];
    assign imm_sx = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    // Source register indices are consumed by the register file, not here.
    assign unused_reg_fields = ^instr[20:16];

    // Instruction decode into ALU controls.
    always_comb begin
        dec       = '0;
        dec.rd    = instr[25:21];
        dec_legal = 1'b1;
        case (opcode)
            OPC_ADD:  begin dec.op = ALU_ADD; dec.in1 = ra_data; dec.in2 = rb_data; end
            OPC_SUB:  begin dec.op = ALU_SUB; dec.in1 = rb_data; dec.in2 = ra_data; end
            OPC_AND:  begin dec.op = ALU_AND; dec.in1 = ra_data; dec.in2 = rb_data; end
            OPC_OR:   begin dec.op = ALU_OR;  dec.in1 = ra_data; dec.in2 = rb_data; end
            OPC_SLW:  begin dec.op = ALU_SLW; dec.in1 = ra_data; dec.shift = instr[4:0]; end
            OPC_SRW:  begin dec.op = ALU_SRW; dec.in1 = ra_data; dec.shift = instr[4:0]; end
            OPC_ADDI: begin dec.op = ALU_ADD; dec.in1 = ra_data; dec.in2 = imm_sx; end
            OPC_LI:   begin dec.op = ALU_ID;  dec.in2 = imm_sx; end
            default:  dec_legal = 1'b0;
        endcase
    end

    assign accept   = in_valid & in_ready_q;
    assign push     = accept & dec_legal;
    assign fire_out = or_valid & out_ready;

    // Output/skid buffer steering; in_ready is low whenever the skid entry is full.
    always_comb begin
        or_d       = or_q;
        sr_d       = sr_q;
        or_valid_d = or_valid;
        sr_full_d  = sr_full;
        if (fire_out) begin
            if (sr_full) begin
                or_d      = sr_q;
                sr_full_d = 1'b0;
            end else if (push) begin
                or_d = dec;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!or_valid) begin
                or_d       = dec;
                or_valid_d = 1'b1;
            end else begin
                sr_d      = dec;
                sr_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            or_q       <= '0;
            sr_q       <= '0;
            or_valid   <= 1'b0;
            sr_full    <= 1'b0;
            in_ready_q <= 1'b0;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            or_q       <= or_d;
            sr_q       <= sr_d;
            or_valid   <= or_valid_d;
            sr_full    <= sr_full_d;
            in_ready_q <= ~sr_full_d;
            illegal_q  <= illegal_q | (accept & ~dec_legal);
            count_q    <= count_q + CNT_W'(fire_out);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = or_valid;
    assign alu_op      = or_q.op;
    assign alu_in1     = or_q.in1;
    assign alu_in2     = or_q.in2;
    assign alu_shift   = or_q.shift;
    assign out_rd      = or_q.rd;
    assign illegal     = illegal_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboarded bench for alu_issue: a reference decoder pushes expected issues at input
// handshake time, a negedge monitor pops and compares on every output handshake.
module tb_alu_issue;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  sh;
        logic [4:0]  rd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       instr = '0;
    logic [DATA_W-1:0] ra_data = '0;
    logic [DATA_W-1:0] rb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [4:0]        alu_shift;
    logic [4:0]        out_rd;
    logic              illegal;
    logic [CNT_W-1:0]  issue_count;

    int   asserts = 0;
    int   fails = 0;
    int   mcount = 0;
    bit   rand_ready = 1'b0;
    bit   prev_hold = 1'b0;
    exp_t prev_act;
    exp_t sbq[$];

    alu_issue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .ra_data(ra_data), .rb_data(rb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
        .out_rd(out_rd), .illegal(illegal), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // Reference decoder straight from the opcode table; ALU codes ADD..ID are 0..6.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, output bit legal);
        exp_t e;
        int opc;
        logic signed [15:0] simm;
        opc   = int'(ins[31:26]);
        simm  = ins[15:0];
        e     = '{op: 3'd0, in1: 32'd0, in2: 32'd0, sh: 5'd0, rd: ins[25:21]};
        legal = 1'b1;
        if (opc == 0)      begin e.op = 3'd0; e.in1 = a; e.in2 = b; end
        else if (opc == 1) begin e.op = 3'd1; e.in1 = b; e.in2 = a; end
        else if (opc == 2) begin e.op = 3'd2; e.in1 = a; e.in2 = b; end
        else if (opc == 3) begin e.op = 3'd3; e.in1 = a; e.in2 = b; end
        else if (opc == 4 || opc == 5) begin
            e.op = 3'(opc); e.in1 = a; e.sh = 5'(ins % 32);
        end
        else if (opc == 8) begin e.op = 3'd0; e.in1 = a; e.in2 = 32'(simm); end
        else if (opc == 9) begin e.op = 3'd6; e.in2 = 32'(simm); end
        else legal = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] mk(input int opc, input int rd, input int imm);
        logic [5:0]  o;
        logic [4:0]  r;
        logic [15:0] im;
        o  = 6'(opc);
        r  = 5'(rd);
        im = 16'(imm);
        return {o, r, 5'd0, im};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output int waits);
        bit   f, legal;
        exp_t e;
        waits    = 0;
        in_valid = 1'b1;
        instr    = ins;
        ra_data  = a;
        rb_data  = b;
        forever begin
            @(negedge clk);
            f = in_ready;
            @(posedge clk);
            if (f) break;
            waits++;
            if (waits > 500) begin
                fails++;
                $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
                $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
                $fatal(1, "send timeout");
            end
        end
        e = model(ins, a, b, legal);
        if (legal) sbq.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sbq.size() == 0 && !out_valid) break;
            n++;
            if (n > 200) begin
                chk("drain_timeout", 64'(sbq.size()), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor plus hold-stability check under backpressure.
    always @(negedge clk) begin
        exp_t act, e;
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            act = '{op: alu_op, in1: alu_in1, in2: alu_in2, sh: alu_shift, rd: out_rd};
            if (prev_hold) begin
                asserts++;
                if (!out_valid || act != prev_act) begin
                    fails++;
                    $display("FAIL hold_stable: got valid=%0b %h, expected valid=1 %h",
                             out_valid, act, prev_act);
                end
            end
            if (out_valid && out_ready) begin
                asserts++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_issue: got %h, expected no issue", act);
                end else begin
                    e = sbq.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL issue_data: got %h, expected %h", act, e);
                    end
                end
                mcount++;
            end
            prev_hold = out_valid && !out_ready;
            prev_act  = act;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int w, stalls, c0;
        int legal_ops[8] = '{0, 1, 2, 3, 4, 5, 8, 9};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_count", 64'(issue_count), 64'd0);
        chk("rst_fields", {alu_in1, alu_in2}, 64'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed decode
        out_ready = 1'b1;
        send(mk(0, 3, 0), 32'd5, 32'd7, w);
        @(negedge clk);
        chk("add_latency_valid", 64'(out_valid), 64'd1);
        chk("add_in1", 64'(alu_in1), 64'd5);
        chk("add_in2", 64'(alu_in2), 64'd7);
        chk("add_rd", 64'(out_rd), 64'd3);
        @(posedge clk); #1;
        send(mk(1, 4, 0), 32'd10, 32'd3, w);
        send(mk(8, 5, 16'hFFFF), 32'd1, 32'd0, w);
        send(mk(9, 6, 16'h8000), 32'd9, 32'd9, w);
        send(mk(4, 7, 31), 32'h8000_0001, 32'd0, w);
        send(mk(5, 8, 4), 32'h8000_0000, 32'd0, w);
        send(mk(2, 9, 0), 32'hF0F0_1234, 32'h0FF0_FFFF, w);
        send(mk(3, 10, 0), 32'hF000_0000, 32'h0000_000F, w);
        send(mk(8, 11, 16'h7FFF), 32'd1, 32'd0, w);
        drain();

        // Backpressure: A to output reg, B to skid, C held off
        out_ready = 1'b0;
        send(mk(0, 1, 0), 32'd100, 32'd1, w);
        send(mk(0, 2, 0), 32'd200, 32'd2, w);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        fork
            send(mk(0, 3, 0), 32'd300, 32'd3, w);
            begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
        join
        chk("bp_c_waited", 64'(w > 0), 64'd1);
        drain();
        chk("count_after_bp", 64'(issue_count), 64'(mcount % 16));

        // Full-rate stream with constant out_ready
        stalls = 0;
        c0 = mcount;
        for (int i = 0; i < 100; i++) begin
            send(mk(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 31), $urandom),
                 $urandom, $urandom, w);
            stalls += w;
        end
        drain();
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_issues", 64'(mcount - c0), 64'd100);
        chk("stream_count_wrap", 64'(issue_count), 64'(mcount % 16));
        chk("illegal_clear", 64'(illegal), 64'd0);

        // Illegal opcode between two ADDs
        c0 = mcount;
        send(mk(0, 1, 0), 32'd1, 32'd2, w);
        send(mk(6'h3F, 2, 0), 32'd3, 32'd4, w);
        send(mk(0, 3, 0), 32'd5, 32'd6, w);
        drain();
        chk("illegal_set", 64'(illegal), 64'd1);
        chk("illegal_issues", 64'(mcount - c0), 64'd2);

        // Randomized mix with random backpressure and illegal ops
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int opc;
            opc = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 63)
                                              : legal_ops[$urandom_range(0, 7)];
            send(mk(opc, $urandom_range(0, 31), $urandom), $urandom, $urandom, w);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_ready = 1'b0;
        #2 out_ready = 1'b1;
        drain();
        chk("rand_count", 64'(issue_count), 64'(mcount % 16));
        chk("illegal_sticky", 64'(illegal), 64'd1);

        // Reset with both entries full
        out_ready = 1'b0;
        send(mk(0, 1, 0), 32'd11, 32'd12, w);
        send(mk(1, 2, 0), 32'd13, 32'd14, w);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sbq.delete();
        mcount = 0;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd0);
        chk("rst2_count", 64'(issue_count), 64'd0);
        chk("rst2_illegal", 64'(illegal), 64'd0);
        chk("rst2_fields", {alu_in1, alu_in2}, 64'd0);
        chk("rst2_ctl", {alu_op, alu_shift, out_rd}, 64'd0);
        @(posedge clk); #1 rstn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(mk(9, 4, 16'h1234), 32'd0, 32'd0, w);
        drain();
        chk("post_rst_count", 64'(issue_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
